// File: rtl/urv_line_fill.sv
// Cache-line transfer engine: turns one line request into mem_if traffic,
// a single BEATS-long burst read for fills or BEATS single-beat writes for line writes.

package urv_cfg;
  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_MASK_W  = MEM_DATA_W / 8;
  localparam int MEM_BURST_W = 5;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_t;

  typedef struct packed {
    mem_type_t               req_type;
    logic [MEM_ADDR_W-1:0]   req_addr;
    logic [MEM_DATA_W-1:0]   req_data;
    logic [MEM_MASK_W-1:0]   req_mask;
    logic [MEM_BURST_W-1:0]  req_burst;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
    logic                  resp_last;
  } mem_resp_t;
endpackage

module urv_line_fill
  import urv_cfg::*;
#(
  parameter int  BEATS       = 4,
  localparam int LINE_W      = BEATS * MEM_DATA_W,
  localparam int LINE_MASK_W = BEATS * MEM_MASK_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_req_valid,
  output logic                   line_req_ready,
  input  logic                   line_req_write,
  input  logic [MEM_ADDR_W-1:0]  line_req_addr,
  input  logic [LINE_W-1:0]      line_wdata,
  input  logic [LINE_MASK_W-1:0] line_wmask,
  output logic                   line_resp_valid,
  output logic [LINE_W-1:0]      line_rdata,
  output logic                   line_err,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output mem_req_t               mem_req,
  input  logic                   mem_resp_valid,
  output logic                   mem_resp_ready,
  input  mem_resp_t              mem_resp
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(BEATS * 4);

  localparam logic [MEM_ADDR_W-1:0]  OFF_MASK   = MEM_ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(BEATS - 1);
  localparam logic [MEM_BURST_W-1:0] BURST_LINE = MEM_BURST_W'(BEATS);
  localparam logic [MEM_BURST_W-1:0] BURST_ONE  = MEM_BURST_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [MEM_ADDR_W-1:0]  base;
  logic [LINE_W-1:0]      wdata_q;
  logic [LINE_MASK_W-1:0] wmask_q;
  logic                   idle_q;

  function automatic logic [MEM_ADDR_W-1:0] beat_addr(input logic [MEM_ADDR_W-1:0] base_a,
                                                      input logic [CNT_W-1:0]      k);
    beat_addr = base_a + (MEM_ADDR_W'(k) << 2);
  endfunction

  function automatic logic [MEM_DATA_W-1:0] data_beat(input logic [LINE_W-1:0] line_v,
                                                      input logic [CNT_W-1:0]  k);
    data_beat = line_v[k[IDX_W-1:0] * MEM_DATA_W +: MEM_DATA_W];
  endfunction

  function automatic logic [MEM_MASK_W-1:0] mask_beat(input logic [LINE_MASK_W-1:0] mask_v,
                                                      input logic [CNT_W-1:0]       k);
    mask_beat = mask_v[k[IDX_W-1:0] * MEM_MASK_W +: MEM_MASK_W];
  endfunction

  assign cnt_nxt = cnt + CNT_W'(1);

  // Ready is forced low during reset so no request can slip in on the reset edge.
  assign line_req_ready = idle_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      idle_q          <= 1'b1;
      mem_req_valid   <= 1'b0;
      mem_resp_ready  <= 1'b0;
      line_resp_valid <= 1'b0;
      line_err        <= 1'b0;
      line_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_req_valid) begin
            base             <= line_req_addr & ~OFF_MASK;
            wdata_q          <= line_wdata;
            wmask_q          <= line_wmask;
            cnt              <= '0;
            idle_q           <= 1'b0;
            mem_req_valid    <= 1'b1;
            mem_req.req_addr <= line_req_addr & ~OFF_MASK;
            if (line_req_write) begin
              state             <= WR_REQ;
              mem_req.req_type  <= MEM_WRITE;
              mem_req.req_data  <= data_beat(line_wdata, '0);
              mem_req.req_mask  <= mask_beat(line_wmask, '0);
              mem_req.req_burst <= BURST_ONE;
            end else begin
              state             <= RD_REQ;
              mem_req.req_type  <= MEM_READ;
              mem_req.req_data  <= '0;
              mem_req.req_mask  <= '0;
              mem_req.req_burst <= BURST_LINE;
            end
          end
        end

        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= RD_DATA;
          end
        end

        // Completion follows the beat count; resp_last only feeds the error flag.
        RD_DATA: begin
          if (mem_resp_valid) begin
            line_rdata[cnt[IDX_W-1:0] * MEM_DATA_W +: MEM_DATA_W] <= mem_resp.resp_data;
            cnt <= cnt_nxt;
            if (mem_resp.resp_last != (cnt == LAST_CNT)) begin
              line_err <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              mem_resp_ready  <= 1'b0;
              line_resp_valid <= 1'b1;
              state           <= DONE;
            end
          end
        end

        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= WR_RESP;
          end
        end

        // Each write is its own one-beat burst, so every ack must carry resp_last.
        WR_RESP: begin
          if (mem_resp_valid) begin
            cnt            <= cnt_nxt;
            mem_resp_ready <= 1'b0;
            if (!mem_resp.resp_last) begin
              line_err <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              line_resp_valid <= 1'b1;
              state           <= DONE;
            end else begin
              mem_req_valid    <= 1'b1;
              mem_req.req_addr <= beat_addr(base, cnt_nxt);
              mem_req.req_data <= data_beat(wdata_q, cnt_nxt);
              mem_req.req_mask <= mask_beat(wmask_q, cnt_nxt);
              state            <= WR_REQ;
            end
          end
        end

        DONE: begin
          line_resp_valid <= 1'b0;
          idle_q          <= 1'b1;
          state           <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_line_fill.sv
// Directed bench for urv_line_fill: vector table of line transactions against a
// scripted mem_if responder, plus hand sequences for reset, spurious beats and back-to-back.

module tb_urv_line_fill;
  import urv_cfg::*;

  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * 32;

  logic                 clk;
  logic                 rst;
  logic                 line_req_valid;
  logic                 line_req_ready;
  logic                 line_req_write;
  logic [31:0]          line_req_addr;
  logic [LINE_W-1:0]    line_wdata;
  logic [BEATS*4-1:0]   line_wmask;
  logic                 line_resp_valid;
  logic [LINE_W-1:0]    line_rdata;
  logic                 line_err;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  mem_req_t             mem_req;
  logic                 mem_resp_valid;
  logic                 mem_resp_ready;
  mem_resp_t            mem_resp;

  urv_line_fill #(.BEATS(BEATS)) dut (
    .clk             (clk),
    .rst             (rst),
    .line_req_valid  (line_req_valid),
    .line_req_ready  (line_req_ready),
    .line_req_write  (line_req_write),
    .line_req_addr   (line_req_addr),
    .line_wdata      (line_wdata),
    .line_wmask      (line_wmask),
    .line_resp_valid (line_resp_valid),
    .line_rdata      (line_rdata),
    .line_err        (line_err),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req         (mem_req),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_ready  (mem_resp_ready),
    .mem_resp        (mem_resp)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic [127:0] rd_line;
    int           stall;
    int           err_beat;
    logic [31:0]  exp_base;
    int           exp_lat;
    logic [127:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t tbl[5];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // responder state
  logic [127:0] rd_line;
  int           rd_left, rd_idx, wr_wait, stall_left, err_beat, req_n;
  bit           wr_pending, hold_valid, spur;
  mem_req_t     hold_req;
  mem_req_t     log_req[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Zero-wait memory model: read data streams from the cycle after the request
  // handshake; a write ack is registered and arrives one cycle later than that.
  task automatic respond();
    forever begin
      @(negedge clk);
      mem_resp_valid     = 1'b0;
      mem_resp.resp_data = '0;
      mem_resp.resp_last = 1'b0;
      if (rst) begin
        rd_left       = 0;
        wr_pending    = 1'b0;
        wr_wait       = 0;
        hold_valid    = 1'b0;
        mem_req_ready = 1'b1;
      end else begin
        if (spur) begin
          mem_resp_valid     = 1'b1;
          mem_resp.resp_data = 32'hBAD0BAD0;
          mem_resp.resp_last = 1'b1;
          spur               = 1'b0;
        end else if (rd_left > 0) begin
          mem_resp_valid     = 1'b1;
          mem_resp.resp_data = rd_line[rd_idx*32 +: 32];
          mem_resp.resp_last = (rd_idx == BEATS - 1) || (rd_idx == err_beat);
          if (mem_resp_ready) begin
            rd_idx++;
            rd_left--;
          end
        end else if (wr_pending) begin
          if (wr_wait > 0) begin
            wr_wait--;
          end else begin
            mem_resp_valid     = 1'b1;
            mem_resp.resp_last = 1'b1;
            if (mem_resp_ready) wr_pending = 1'b0;
          end
        end
        if (mem_req_valid && stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
        end
        if (mem_req_valid && hold_valid) chk("req_stable", 128'(mem_req), 128'(hold_req));
        hold_valid = mem_req_valid && !mem_req_ready;
        hold_req   = mem_req;
        if (mem_req_valid && mem_req_ready) begin
          if (req_n < 8) log_req[req_n[2:0]] = mem_req;
          req_n++;
          if (mem_req.req_type == MEM_READ) begin
            rd_left = BEATS;
            rd_idx  = 0;
          end else begin
            wr_pending = 1'b1;
            wr_wait    = 1;
          end
        end
      end
    end
  endtask

  task automatic wait_pulse(input string name, output int at);
    at = -1;
    for (int n = 0; n < 80; n++) begin
      if (line_resp_valid) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no line_resp_valid within 80 cycles", name);
    end
  endtask

  task automatic run_txn(input int i);
    vec_t     v;
    int       t0, at;
    mem_req_t e;
    v          = tbl[i];
    rd_line    = v.rd_line;
    stall_left = v.stall;
    err_beat   = v.err_beat;
    req_n      = 0;
    chk($sformatf("v%0d_ready", i), 128'(line_req_ready), 128'(1'b1));
    line_req_valid = 1'b1;
    line_req_write = v.wr;
    line_req_addr  = v.addr;
    line_wdata     = v.wdata;
    line_wmask     = v.wmask;
    t0             = cyc;
    tick();
    line_req_valid = 1'b0;
    wait_pulse($sformatf("v%0d_pulse", i), at);
    chk($sformatf("v%0d_latency", i), 128'(at - t0), 128'(v.exp_lat));
    chk($sformatf("v%0d_rdata", i), line_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", i), 128'(line_err), 128'(v.exp_err));
    tick();
    chk($sformatf("v%0d_one_pulse", i), 128'(line_resp_valid), 128'(1'b0));
    chk($sformatf("v%0d_ready_after", i), 128'(line_req_ready), 128'(1'b1));
    if (v.wr) begin
      chk($sformatf("v%0d_wr_count", i), 128'(req_n), 128'(BEATS));
      for (int k = 0; k < BEATS; k++) begin
        e = log_req[3'(k)];
        chk($sformatf("v%0d_b%0d_type", i, k), 128'(e.req_type), 128'(MEM_WRITE));
        chk($sformatf("v%0d_b%0d_addr", i, k), 128'(e.req_addr), 128'(v.exp_base + 32'(4 * k)));
        chk($sformatf("v%0d_b%0d_data", i, k), 128'(e.req_data), 128'(v.wdata[k*32 +: 32]));
        chk($sformatf("v%0d_b%0d_mask", i, k), 128'(e.req_mask), 128'(v.wmask[k*4 +: 4]));
        chk($sformatf("v%0d_b%0d_burst", i, k), 128'(e.req_burst), 128'(1));
      end
    end else begin
      chk($sformatf("v%0d_rd_count", i), 128'(req_n), 128'(1));
      e = log_req[0];
      chk($sformatf("v%0d_type", i), 128'(e.req_type), 128'(MEM_READ));
      chk($sformatf("v%0d_addr", i), 128'(e.req_addr), 128'(v.exp_base));
      chk($sformatf("v%0d_burst", i), 128'(e.req_burst), 128'(BEATS));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 128'(line_req_ready), 128'(1'b0));
    chk({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(1'b0));
    chk({tag, "_mem_resp_ready"}, 128'(mem_resp_ready), 128'(1'b0));
    chk({tag, "_resp_valid"}, 128'(line_resp_valid), 128'(1'b0));
    chk({tag, "_err"}, 128'(line_err), 128'(1'b0));
    chk({tag, "_rdata"}, line_rdata, 128'h0);
  endtask

  initial begin
    int at, t0, t1, pulses;

    rst            = 1'b1;
    line_req_valid = 1'b0;
    line_req_write = 1'b0;
    line_req_addr  = '0;
    line_wdata     = '0;
    line_wmask     = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp       = '0;
    rd_line        = '0;
    rd_left        = 0;
    rd_idx         = 0;
    wr_wait        = 0;
    wr_pending     = 1'b0;
    hold_valid     = 1'b0;
    hold_req       = '0;
    stall_left     = 0;
    err_beat       = -1;
    req_n          = 0;
    spur           = 1'b0;
    fork
      respond();
    join_none

    //          wr    addr          wdata                                   wmask     rd_line                                 stall err base          lat exp_rdata                               err
    tbl[0] = '{1'b0, 32'h0000_0104, 128'h0,                                 16'h0000, 128'h0000000D_0000000C_0000000B_0000000A, 0, -1, 32'h0000_0100,  6, 128'h0000000D_0000000C_0000000B_0000000A, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0200, 128'h44444444_33333333_22222222_11111111, 16'hF0F0, 128'h0,                                 0, -1, 32'h0000_0200, 13, 128'h0000000D_0000000C_0000000B_0000000A, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_030C, 128'h0,                                 16'h0000, 128'h00000004_00000003_00000002_00000001, 3, -1, 32'h0000_0300,  9, 128'h00000004_00000003_00000002_00000001, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_041F, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 16'hFFFF, 128'h0,                                 3, -1, 32'h0000_0410, 16, 128'h00000004_00000003_00000002_00000001, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_05F8, 128'h0,                                 16'h0000, 128'h89ABCDEF_01234567_DEADBEEF_55AA55AA, 0,  1, 32'h0000_05F0,  6, 128'h89ABCDEF_01234567_DEADBEEF_55AA55AA, 1'b1};

    tick();
    tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();
    chk("por_ready_after", 128'(line_req_ready), 128'(1'b1));

    for (int i = 0; i < 5; i++) run_txn(i);

    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("err_sticky_%0d", n), 128'(line_err), 128'(1'b1));
    end

    // a stray response beat while idle must not touch the line buffer
    spur = 1'b1;
    tick();
    tick();
    chk("spur_rdata", line_rdata, tbl[4].exp_rdata);
    chk("spur_resp_valid", 128'(line_resp_valid), 128'(1'b0));
    chk("spur_ready", 128'(line_req_ready), 128'(1'b1));

    // reset in the middle of a fill burst
    rd_line        = 128'h77770003_77770002_77770001_77770000;
    stall_left     = 0;
    err_beat       = -1;
    rd_idx         = 0;
    line_req_valid = 1'b1;
    line_req_write = 1'b0;
    line_req_addr  = 32'h0000_0700;
    tick();
    line_req_valid = 1'b0;
    at = -1;
    for (int n = 0; n < 30; n++) begin
      if (rd_idx >= 3) begin
        at = n;
        break;
      end
      tick();
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL rst_mid_wait: fill beats never reached 3 within 30 cycles");
    end
    rst = 1'b1;
    tick();
    check_reset_outputs("mid");
    rst = 1'b0;
    tick();
    chk("mid_ready_after", 128'(line_req_ready), 128'(1'b1));
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (line_resp_valid) pulses++;
      tick();
    end
    chk("mid_no_pulse", 128'(pulses), 128'(0));
    chk("mid_rdata_clear", line_rdata, 128'h0);
    run_txn(0);

    // back-to-back: request held high across the first completion
    rd_line        = 128'h11110003_11110002_11110001_11110000;
    req_n          = 0;
    line_req_valid = 1'b1;
    line_req_write = 1'b0;
    line_req_addr  = 32'h0000_0800;
    t0             = cyc;
    tick();
    line_req_addr  = 32'h0000_0904;
    wait_pulse("b2b_pulse1", at);
    chk("b2b_lat1", 128'(at - t0), 128'(6));
    chk("b2b_rdata1", line_rdata, 128'h11110003_11110002_11110001_11110000);
    chk("b2b_ready_done", 128'(line_req_ready), 128'(1'b0));
    chk("b2b_addr1", 128'(log_req[0].req_addr), 128'(32'h0000_0800));
    rd_line = 128'h22220003_22220002_22220001_22220000;
    req_n   = 0;
    tick();
    chk("b2b_ready_next", 128'(line_req_ready), 128'(1'b1));
    t1 = cyc;
    tick();
    line_req_valid = 1'b0;
    wait_pulse("b2b_pulse2", at);
    chk("b2b_lat2", 128'(at - t1), 128'(6));
    chk("b2b_rdata2", line_rdata, 128'h22220003_22220002_22220001_22220000);
    chk("b2b_count2", 128'(req_n), 128'(1));
    chk("b2b_addr2", 128'(log_req[0].req_addr), 128'(32'h0000_0900));
    tick();
    chk("b2b_idle", 128'(line_req_ready), 128'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/urv_line_fill.md
URV_LINE_FILL -- requirements
Module: urv_line_fill

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning 32-bit words per line (power of two, 2..16).
REQ-002 SHALL derive LINE_W = BEATS*MEM_DATA_W and LINE_MASK_W = BEATS*MEM_MASK_W, using MEM_ADDR_W, MEM_DATA_W and MEM_MASK_W from urv_cfg.
REQ-003 SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 line_req_valid  input  1  line request present.
REQ-007 line_req_ready  output  1  block can accept a line request.
REQ-008 line_req_write  input  1  1 = line write, 0 = line fill (read).
REQ-009 line_req_addr  input  MEM_ADDR_W  line byte address; low log2(BEATS*4) bits ignored.
REQ-010 line_wdata  input  LINE_W  write data; beat k is bits [k*32 +: 32].
REQ-011 line_wmask  input  LINE_MASK_W  active-high byte enables; beat k is bits [k*4 +: 4].
REQ-012 line_resp_valid  output  1  one-cycle completion pulse.
REQ-013 line_rdata  output  LINE_W  assembled fill data; beat k in bits [k*32 +: 32].
REQ-014 line_err  output  1  sticky resp_last protocol error flag.
REQ-015 mem_req_valid / mem_req_ready / mem_req (mem_req_t)  out/in/out  mem_if request channel, initiator side.
REQ-016 mem_resp_valid / mem_resp_ready / mem_resp (mem_resp_t)  in/out/in  mem_if response channel, initiator side.

Function
REQ-017 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-018 IDLE: line_req_ready=1; on line_req_valid SHALL register the request, force the address low bits to 0, clear the beat counter, and go to WR_REQ if write, else RD_REQ.
REQ-019 RD_REQ: mem_req_valid=1, req_type=MEM_READ, req_addr=base, req_burst=BEATS; on mem_req_ready -> RD_DATA.
REQ-020 RD_DATA: mem_resp_ready=1; each mem_resp_valid beat SHALL write resp_data into line_rdata slice [cnt] and increment cnt; on beat BEATS-1 -> DONE.
REQ-021 WR_REQ: mem_req_valid=1, req_type=MEM_WRITE, req_addr=base+4*cnt, req_data/req_mask = beat cnt slices, req_burst=1; on mem_req_ready -> WR_RESP.
REQ-022 WR_RESP: mem_resp_ready=1; on mem_resp_valid, cnt++; go to DONE if cnt was BEATS-1, else WR_REQ.
REQ-023 DONE: line_resp_valid=1 for exactly one cycle, then IDLE; line_req_ready=0 in DONE.
REQ-024 mem_req fields SHALL be held stable while mem_req_valid=1 and mem_req_ready=0.
REQ-025 Beat counter SHALL be log2(BEATS)+1 bits wide; address adds SHALL wrap modulo 2^MEM_ADDR_W.
REQ-026 line_err SHALL set when resp_last differs from (beat is final of its burst), and SHALL stay set until reset; completion SHALL be decided by count only.
REQ-027 mem_resp_valid outside RD_DATA/WR_RESP SHALL be ignored and SHALL NOT change line_rdata or cnt.
REQ-028 line_rdata SHALL hold its value until the next fill beat is written; write lines SHALL NOT modify it.
REQ-029 Latency with a zero-wait responder: read accepted at cycle T -> line_resp_valid at T+BEATS+2; write -> T+3*BEATS+1.

Reset
REQ-030 While rst=1: state=IDLE, cnt=0, mem_req_valid=0, mem_resp_ready=0, line_resp_valid=0, line_err=0, line_rdata=0, line_req_ready=0.
REQ-031 Reset asserted mid-burst SHALL abort the transaction with no line_resp_valid; line_req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-032 Fill: BEATS=4, addr 0x104 -> one mem req (addr 0x100, burst 4); beats 0xA,0xB,0xC,0xD -> line_rdata=0x0000000D_0000000C_0000000B_0000000A, one pulse at T+6.
REQ-033 Write: addr 0x200, mask 0xF0F0 -> four burst-1 writes to 0x200/0x204/0x208/0x20C with masks 0x0,0xF,0x0,0xF; one pulse.
REQ-034 Backpressure: mem_req_ready=0 for 3 cycles -> mem_req held stable, latency grows by 3.
REQ-035 Protocol error: resp_last=1 on beat 1 of a fill -> line_err=1 and stays 1; fill still completes after 4 beats.
REQ-036 Reset: rst pulsed after 2 fill beats -> no line_resp_valid; a new fill then completes correctly.
REQ-037 Back-to-back: line_req_valid held high for two requests -> second accepted in the cycle after the DONE pulse.
